// File: rtl/alu_immediate_issue_stage_pkg.sv
// rv32i_opimm_pkg: shared OP-IMM constants, funct3 codes, issue-stage state enum and funct3 support check.
package rv32i_opimm_pkg;

    localparam int          RV_XLEN      = 32;
    localparam logic [6:0]  OPIMM_OPCODE = 7'b0010011;

    localparam logic [2:0]  F3_ADDI  = 3'd0;
    localparam logic [2:0]  F3_SLLI  = 3'd1;
    localparam logic [2:0]  F3_SLTI  = 3'd2;
    localparam logic [2:0]  F3_SLTIU = 3'd3;
    localparam logic [2:0]  F3_XORI  = 3'd4;
    localparam logic [2:0]  F3_SRXI  = 3'd5;
    localparam logic [2:0]  F3_ORI   = 3'd6;
    localparam logic [2:0]  F3_ANDI  = 3'd7;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_READ,
        ST_EXEC,
        ST_CAPT,
        ST_WB
    } state_t;

    // Shifts (SLLI/SRLI/SRAI) are not handled by the downstream ALU.
    function automatic logic is_supported_funct3(input logic [2:0] f3);
        return (f3 == F3_ADDI) || (f3 == F3_SLTI) || (f3 == F3_SLTIU) ||
               (f3 == F3_XORI) || (f3 == F3_ORI)  || (f3 == F3_ANDI);
    endfunction

endpackage

// File: rtl/alu_immediate_issue_stage_decoder.sv
// opimm_decoder: splits an I-type word into rs1/rd/funct3/sign-extended imm and flags unsupported words.
module opimm_decoder
    import rv32i_opimm_pkg::*;
#(
    parameter int         XLEN   = RV_XLEN,
    parameter logic [6:0] OPCODE = OPIMM_OPCODE
) (
    input  logic [31:0]     instr_i,
    output logic [4:0]      rs1_o,
    output logic [4:0]      rd_o,
    output logic [2:0]      funct3_o,
    output logic [XLEN-1:0] imm_o,
    output logic            illegal_o
);

    assign rs1_o     = instr_i[19:15];
    assign rd_o      = instr_i[11:7];
    assign funct3_o  = instr_i[14:12];
    assign imm_o     = {{(XLEN-12){instr_i[31]}}, instr_i[31:20]};
    assign illegal_o = (instr_i[6:0] != OPCODE) || !is_supported_funct3(instr_i[14:12]);

endmodule

// File: rtl/alu_immediate_issue_stage.sv
// alu_immediate_issue_stage: issues one OP-IMM instruction at a time to the immediate ALU and writes its result back.
// Optional feature macro: OPIMM_RETIRE_COUNTER_EN (enables the retired_count counter).
module alu_immediate_issue_stage
    import rv32i_opimm_pkg::*;
#(
    parameter int         XLEN         = RV_XLEN,
    parameter logic [6:0] OPCODE_OPIMM = OPIMM_OPCODE
) (
    input  logic            clock,
    input  logic            reset_n,
    input  logic            instr_valid,
    output logic            instr_ready,
    input  logic [31:0]     instr,
    output logic [4:0]      rf_read_index,
    input  logic [XLEN-1:0] rf_read_value,
    output logic            alu_enable,
    output logic [2:0]      alu_funct3,
    output logic [XLEN-1:0] alu_rs1_value,
    output logic [XLEN-1:0] alu_immediate,
    input  logic [XLEN-1:0] alu_rd_value,
    output logic            rf_write_enable,
    output logic [4:0]      rf_write_index,
    output logic [XLEN-1:0] rf_write_value,
    output logic            illegal_instr,
    output logic [31:0]     retired_count
);

    state_t          state_q, state_d;
    logic [4:0]      rs1_q, rd_q;
    logic [2:0]      funct3_q;
    logic [XLEN-1:0] imm_q, rs1_value_q, result_q;
    logic            illegal_q;

    logic [4:0]      dec_rs1, dec_rd;
    logic [2:0]      dec_funct3;
    logic [XLEN-1:0] dec_imm;
    logic            dec_illegal;
    logic            take;

    opimm_decoder #(
        .XLEN   (XLEN),
        .OPCODE (OPCODE_OPIMM)
    ) u_dec (
        .instr_i   (instr),
        .rs1_o     (dec_rs1),
        .rd_o      (dec_rd),
        .funct3_o  (dec_funct3),
        .imm_o     (dec_imm),
        .illegal_o (dec_illegal)
    );

    assign take = (state_q == ST_IDLE) && instr_valid;

    // State register; async reset drops any in-flight instruction.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) state_q <= ST_IDLE;
        else          state_q <= state_d;
    end

    // Next-state and per-state strobes.
    always_comb begin
        state_d         = state_q;
        instr_ready     = 1'b0;
        alu_enable      = 1'b0;
        rf_write_enable = 1'b0;
        case (state_q)
            ST_IDLE: begin
                instr_ready = 1'b1;
                if (instr_valid && !dec_illegal) state_d = ST_READ;
            end
            ST_READ: state_d = ST_EXEC;
            ST_EXEC: begin
                alu_enable = 1'b1;
                state_d    = ST_CAPT;
            end
            ST_CAPT: state_d = ST_WB;
            ST_WB: begin
                rf_write_enable = (rd_q != 5'd0);
                state_d         = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Operand, result and illegal-pulse latches; fields only change on a legal accept.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            rs1_q       <= '0;
            rd_q        <= '0;
            funct3_q    <= '0;
            imm_q       <= '0;
            rs1_value_q <= '0;
            result_q    <= '0;
            illegal_q   <= 1'b0;
        end else begin
            illegal_q <= take && dec_illegal;
            if (take && !dec_illegal) begin
                rs1_q    <= dec_rs1;
                rd_q     <= dec_rd;
                funct3_q <= dec_funct3;
                imm_q    <= dec_imm;
            end
            if (state_q == ST_READ) rs1_value_q <= rf_read_value;
            if (state_q == ST_CAPT) result_q    <= alu_rd_value;
        end
    end

    // The regfile samples the index on the accept edge, so the live rs1 is shown while a word is offered.
    assign rf_read_index  = take ? dec_rs1 : rs1_q;
    assign alu_funct3     = funct3_q;
    assign alu_rs1_value  = rs1_value_q;
    assign alu_immediate  = imm_q;
    assign rf_write_index = (state_q == ST_WB) ? rd_q : 5'd0;
    assign rf_write_value = (state_q == ST_WB) ? result_q : '0;
    assign illegal_instr  = illegal_q;

`ifdef OPIMM_RETIRE_COUNTER_EN
    logic [31:0] count_q, count_d;

    assign count_d = (state_q == ST_WB) ? count_q + 32'd1 : count_q;

    // Retire counter, wraps silently; illegal words never reach WB.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) count_q <= '0;
        else          count_q <= count_d;
    end

    assign retired_count = count_q;
`else
    assign retired_count = 32'd0;
`endif

endmodule
